word_assembler: RTL and testbench
=================================

WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning byte order (1: first byte lands in o_word[31:24]; 0: first byte lands in o_word[7:0]).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning inter-byte idle limit in clk cycles (16..2^24-1).
REQ-003 SHALL have parameter SYNC_WORD, default 32'hAAAAAAAA, meaning the frame start code.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst_n  input  1  reset: asynchronous, active-low.
REQ-006 rx_byte  input  8  byte from the UART receiver; valid only while rx_valid=1.
REQ-007 rx_valid  input  1  one-cycle strobe: rx_byte is a new byte.
REQ-008 rx_err  input  1  one-cycle strobe: framing/stop-bit error on the current byte.
REQ-009 o_word  output  32  last completed signed word.
REQ-010 word_avail  output  1  level: o_word is a fresh, complete word.
REQ-011 sync_seen  output  1  high while word_avail=1 and o_word==SYNC_WORD.
REQ-012 drop  output  1  one-cycle pulse: partial word discarded.

Function
REQ-013 SHALL keep byte counter cnt (0..3) and 32-bit shift register sr; states EMPTY (cnt=0) and PARTIAL (cnt=1..3).
REQ-014 On rx_valid=1 with rx_err=0: byte SHALL be shifted into sr per MSB_FIRST and cnt SHALL increment; on the 4th byte cnt SHALL wrap to 0.
REQ-015 Cycle after the 4th byte is accepted: o_word SHALL load the assembled word and word_avail SHALL go high (latency 1 cycle from 4th rx_valid).
REQ-016 word_avail SHALL stay high, and o_word SHALL stay stable, until the first byte of the next word is accepted; word_avail SHALL fall in the cycle after that byte.
REQ-017 o_word SHALL change only when a full word completes; partial words SHALL never be visible.
REQ-018 rx_err=1 (with or without rx_valid) SHALL discard the current byte and any partial word: cnt<=0, sr<=0; drop pulses only if cnt was nonzero; word_avail and o_word unaffected.
REQ-019 rx_err and rx_valid in the same cycle: rx_err SHALL win.
REQ-020 Back-to-back rx_valid on consecutive cycles SHALL be accepted without loss.
REQ-021 sync_seen SHALL be combinational from word_avail and o_word.

Reset
REQ-022 rst_n low SHALL asynchronously force cnt=0, sr=0, idle counter=0, o_word=0, word_avail=0, sync_seen=0, drop=0.
REQ-023 Reset mid-word SHALL discard the partial word without a drop pulse; first byte after release starts a new word.

Configuration
REQ-024 Macro WORD_TIMEOUT_EN: when defined, an idle counter SHALL count cycles without rx_valid while cnt!=0, clear on every accepted byte and when cnt=0; reaching TIMEOUT_CYCLES SHALL set cnt<=0, sr<=0 and pulse drop for one cycle.
REQ-025 Without WORD_TIMEOUT_EN: no idle counter SHALL be built; a partial word SHALL wait indefinitely; drop SHALL pulse only from rx_err.
REQ-026 Timeout and rx_valid in the same cycle: byte SHALL be accepted, no timeout.

Verification
REQ-027 MSB_FIRST=1, bytes 12,34,56,78 -> o_word=32'h12345678, word_avail high 1 cycle after 4th byte.
REQ-028 MSB_FIRST=0, same bytes -> o_word=32'h78563412.
REQ-029 Bytes AA,AA,AA,AA -> sync_seen=1; next byte 01 -> word_avail and sync_seen fall next cycle, o_word still 32'hAAAAAAAA.
REQ-030 Bytes 11,22, rx_err, then 33,44,55,66 -> drop pulse once, o_word=32'h33445566.
REQ-031 WORD_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte 11, 16 idle cycles -> drop pulse; then 01,02,03,04 -> o_word=32'h01020304.
REQ-032 rst_n low after two bytes of a word -> all outputs 0 immediately; four new bytes A0,B0,C0,D0 -> o_word=32'hA0B0C0D0.

Source files
------------

// File: rtl/word_assembler.sv
// Collects UART bytes into 32-bit words and holds the last complete word until the next word starts.
// Optional build macro WORD_TIMEOUT_EN adds an inter-byte idle timeout that discards stale partial words.
module word_assembler #(
    parameter int unsigned MSB_FIRST      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] SYNC_WORD      = 32'hAAAAAAAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [31:0] o_word,
    output logic        word_avail,
    output logic        sync_seen,
    output logic        drop
);

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_PARTIAL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] o_word_q, o_word_d;
    logic        word_avail_q, word_avail_d;
    logic        drop_q, drop_d;
    logic        accept_s;
    logic        timeout_s;

    // Places a new byte into the shift register according to the configured byte order.
    function automatic logic [31:0] shift_in(input logic [31:0] sr, input logic [7:0] b);
        if (MSB_FIRST != 0) begin
            return {sr[23:0], b};
        end else begin
            return {b, sr[31:8]};
        end
    endfunction

    assign accept_s = rx_valid & ~rx_err;

`ifdef WORD_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LIM = 24'(TIMEOUT_CYCLES);

    logic [23:0] idle_q, idle_d;

    // Idle counter: runs only while a partial word waits; an arriving byte always beats the timeout.
    always_comb begin
        idle_d    = idle_q;
        timeout_s = 1'b0;
        if (accept_s || rx_err || (state_q == ST_EMPTY)) begin
            idle_d = 24'd0;
        end else if (!rx_valid) begin
            if ((idle_q + 24'd1) == TIMEOUT_LIM) begin
                timeout_s = 1'b1;
                idle_d    = 24'd0;
            end else begin
                idle_d = idle_q + 24'd1;
            end
        end else begin
            idle_d = idle_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 24'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic: error discards first, then byte acceptance, then timeout.
    always_comb begin
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        o_word_d     = o_word_q;
        word_avail_d = word_avail_q;
        drop_d       = 1'b0;
        if (rx_err) begin
            cnt_d  = 2'd0;
            sr_d   = 32'd0;
            drop_d = (state_q == ST_PARTIAL);
        end else if (rx_valid) begin
            case (cnt_q)
                2'd0: begin
                    // First byte of a new word retires the previously held word.
                    sr_d         = shift_in(sr_q, rx_byte);
                    cnt_d        = 2'd1;
                    word_avail_d = 1'b0;
                end
                2'd1, 2'd2: begin
                    sr_d  = shift_in(sr_q, rx_byte);
                    cnt_d = cnt_q + 2'd1;
                end
                2'd3: begin
                    o_word_d     = shift_in(sr_q, rx_byte);
                    word_avail_d = 1'b1;
                    sr_d         = 32'd0;
                    cnt_d        = 2'd0;
                end
                default: begin
                    cnt_d = 2'd0;
                    sr_d  = 32'd0;
                end
            endcase
        end else if (timeout_s) begin
            cnt_d  = 2'd0;
            sr_d   = 32'd0;
            drop_d = 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_d == 2'd0) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    // Assembly state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            cnt_q        <= 2'd0;
            sr_q         <= 32'd0;
            o_word_q     <= 32'd0;
            word_avail_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            o_word_q     <= o_word_d;
            word_avail_q <= word_avail_d;
            drop_q       <= drop_d;
        end
    end

    assign o_word     = o_word_q;
    assign word_avail = word_avail_q;
    assign drop       = drop_q;
    assign sync_seen  = word_avail_q && (o_word_q == SYNC_WORD);

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: one MSB-first and one LSB-first instance driven by the same byte stream.
module tb_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [31:0] o_word_m, o_word_l;
    logic        avail_m, avail_l, sync_m, sync_l, drop_m, drop_l;

    int n_checks = 0;
    int n_fail   = 0;

    word_assembler #(.MSB_FIRST(1), .TIMEOUT_CYCLES(16), .SYNC_WORD(32'hAAAAAAAA)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
        .o_word(o_word_m), .word_avail(avail_m), .sync_seen(sync_m), .drop(drop_m)
    );

    word_assembler #(.MSB_FIRST(0), .TIMEOUT_CYCLES(16), .SYNC_WORD(32'hAAAAAAAA)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
        .o_word(o_word_l), .word_avail(avail_l), .sync_seen(sync_l), .drop(drop_l)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus, applied on the falling edge; outputs are sampled at that same point.
    task automatic cyc(input logic v, input logic e, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_err   = e;
        rx_byte  = b;
    endtask

    task automatic send4(input logic [31:0] w);
        cyc(1'b1, 1'b0, w[31:24]);
        cyc(1'b1, 1'b0, w[23:16]);
        cyc(1'b1, 1'b0, w[15:8]);
        cyc(1'b1, 1'b0, w[7:0]);
        cyc(1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        #1;
        check_eq("rst_o_word", o_word_m, 32'd0);
        check_eq("rst_avail", {31'd0, avail_m}, 32'd0);
        check_eq("rst_sync", {31'd0, sync_m}, 32'd0);
        check_eq("rst_drop", {31'd0, drop_m}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic assembly, both byte orders, latency one cycle
        cyc(1'b1, 1'b0, 8'h12);
        cyc(1'b1, 1'b0, 8'h34);
        cyc(1'b1, 1'b0, 8'h56);
        cyc(1'b1, 1'b0, 8'h78);
        check_eq("partial_hidden_avail", {31'd0, avail_m}, 32'd0);
        check_eq("partial_hidden_word", o_word_m, 32'd0);
        cyc(1'b0, 1'b0, 8'd0);
        check_eq("msb_word", o_word_m, 32'h12345678);
        check_eq("msb_avail", {31'd0, avail_m}, 32'd1);
        check_eq("lsb_word", o_word_l, 32'h78563412);
        check_eq("no_sync", {31'd0, sync_m}, 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 8'd0);
        check_eq("hold_word", o_word_m, 32'h12345678);
        check_eq("hold_avail", {31'd0, avail_m}, 32'd1);

        // Sync word, then first byte of next word retires it
        send4(32'hAAAAAAAA);
        check_eq("sync_seen", {31'd0, sync_m}, 32'd1);
        check_eq("sync_seen_lsb", {31'd0, sync_l}, 32'd1);
        cyc(1'b1, 1'b0, 8'h01);
        check_eq("sync_before_fall", {31'd0, sync_m}, 32'd1);
        cyc(1'b0, 1'b0, 8'd0);
        check_eq("avail_fell", {31'd0, avail_m}, 32'd0);
        check_eq("sync_fell", {31'd0, sync_m}, 32'd0);
        check_eq("word_kept", o_word_m, 32'hAAAAAAAA);

        // Error discards partial word (01,11,22 pending)
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("err_drop", {31'd0, drop_m}, 32'd1);
        check_eq("err_word_kept", o_word_m, 32'hAAAAAAAA);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("err_drop_once", {31'd0, drop_m}, 32'd0);
        send4(32'h33445566);
        check_eq("after_err_word", o_word_m, 32'h33445566);
        check_eq("after_err_avail", {31'd0, avail_m}, 32'd1);

        // Error while empty: no drop, word_avail unaffected
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("empty_err_nodrop", {31'd0, drop_m}, 32'd0);
        check_eq("empty_err_avail", {31'd0, avail_m}, 32'd1);

        // rx_err wins over rx_valid
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("err_wins_drop", {31'd0, drop_m}, 32'd1);
        check_eq("err_wins_word", o_word_m, 32'h33445566);
        send4(32'h9ABCDEF0);
        check_eq("err_wins_after", o_word_m, 32'h9ABCDEF0);
        check_eq("err_wins_after_lsb", o_word_l, 32'hF0DEBC9A);

        // Idle timeout (or, without it, indefinite wait)
        cyc(1'b1, 1'b0, 8'h11);
        repeat (16) cyc(1'b0, 1'b0, 8'h00);
`ifdef WORD_TIMEOUT_EN
        check_eq("to_not_yet", {31'd0, drop_m}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("to_drop", {31'd0, drop_m}, 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("to_drop_once", {31'd0, drop_m}, 32'd0);
        send4(32'h01020304);
        check_eq("to_after_word", o_word_m, 32'h01020304);
`else
        repeat (8) cyc(1'b0, 1'b0, 8'h00);
        check_eq("no_to_drop", {31'd0, drop_m}, 32'd0);
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("no_to_word", o_word_m, 32'h11010203);
`endif
        check_eq("to_avail", {31'd0, avail_m}, 32'd1);

        // Asynchronous reset mid-word
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b0, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_word", o_word_m, 32'd0);
        check_eq("arst_avail", {31'd0, avail_m}, 32'd0);
        check_eq("arst_sync", {31'd0, sync_m}, 32'd0);
        check_eq("arst_drop", {31'd0, drop_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        check_eq("arst_nodrop", {31'd0, drop_m}, 32'd0);
        send4(32'hA0B0C0D0);
        check_eq("arst_new_word", o_word_m, 32'hA0B0C0D0);
        check_eq("arst_new_lsb", o_word_l, 32'hD0C0B0A0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
